// File: rtl/div_pkg.sv
// Shared definitions for the arbitrated sequential divider.
package div_pkg;

  // Default operand/result width
  localparam int unsigned DefaultW = 8;

  // Controller states
  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

  // Requester identifier (two requesters)
  typedef logic id_t;

endpackage

// File: rtl/div_core.sv
// Restoring-division datapath: operand load, one quotient bit per step,
// step counter and held result registers.
module div_core
  import div_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  input  logic         i_step,
  input  logic         i_zero_fin,
  output logic         o_last,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder,
  output logic         o_err
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]    r_dvd;   // dividend bits shifting out, quotient bits shifting in
  logic [W-1:0]    r_div;
  logic [W-1:0]    r_rem;
  logic [CntW-1:0] r_cnt;
  logic [W-1:0]    r_quo_res;
  logic [W-1:0]    r_rem_res;
  logic            r_err;

  logic [W:0]   w_shift;
  logic [W:0]   w_diff;
  logic         w_qbit;
  logic [W-1:0] w_rem_nxt;
  logic [W-1:0] w_quo_nxt;

  // Trial subtraction; the W+1-bit difference MSB is the borrow
  always_comb begin
    w_shift   = {r_rem, r_dvd[W-1]};
    w_diff    = w_shift - {1'b0, r_div};
    w_qbit    = ~w_diff[W];
    w_rem_nxt = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
    w_quo_nxt = {r_dvd[W-2:0], w_qbit};
  end

  assign o_last = (r_cnt == CntW'(W - 1));

  // Working registers: load on grant, advance one bit per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_dvd <= i_dividend;
      r_div <= i_divisor;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_dvd <= w_quo_nxt;
      r_rem <= w_rem_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result registers: written only at completion, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo_res <= '0;
      r_rem_res <= '0;
      r_err     <= 1'b0;
    end else if (i_zero_fin) begin
      r_quo_res <= '1;
      r_rem_res <= '1;
      r_err     <= 1'b1;
    end else if (i_step && o_last) begin
      r_quo_res <= w_quo_nxt;
      r_rem_res <= w_rem_nxt;
      r_err     <= 1'b0;
    end
  end

  assign o_quotient  = r_quo_res;
  assign o_remainder = r_rem_res;
  assign o_err       = r_err;

endmodule

// File: rtl/div_arbiter_seq.sv
// Two-requester round-robin arbiter in front of a W-cycle restoring divider.
// Optional macro DIV_ZERO_FLAG_EN: a zero divisor skips iteration and
// completes next cycle with all-ones results and err set.
module div_arbiter_seq
  import div_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] dividend0,
  input  logic [W-1:0] divisor0,
  input  logic [W-1:0] dividend1,
  input  logic [W-1:0] divisor1,
  output logic [1:0]   gnt,
  output logic         busy,
  output logic [1:0]   done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         err
);

  state_e r_state;
  state_e w_state_nxt;
  id_t    r_owner;
  id_t    r_prio;   // requester favoured on contention
  id_t    w_win;

  logic         w_grant;
  logic         w_step;
  logic         w_last;
  logic         w_zero_fin;
  logic [W-1:0] w_dividend;
  logic [W-1:0] w_divisor;

  // Round-robin pick and operand mux
  always_comb begin
    if (&req) w_win = r_prio;
    else      w_win = req[1];
    w_dividend = w_win ? dividend1 : dividend0;
    w_divisor  = w_win ? divisor1  : divisor0;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic w_div_zero;
  assign w_div_zero = (w_divisor == '0);
  assign w_zero_fin = w_grant & w_div_zero;
`else
  assign w_zero_fin = 1'b0;
`endif

  // Next-state and grant/done decode
  always_comb begin
    w_state_nxt = r_state;
    gnt         = 2'b00;
    done        = 2'b00;
    w_grant     = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|req) begin
          w_grant     = 1'b1;
          gnt[w_win]  = 1'b1;
          w_state_nxt = StIter;
`ifdef DIV_ZERO_FLAG_EN
          if (w_div_zero) w_state_nxt = StDone;
`endif
        end
      end
      StIter: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        done[r_owner] = 1'b1;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State, owner and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner <= w_win;
        r_prio  <= ~w_win;
      end
    end
  end

  assign busy = (r_state != StIdle);

  div_core #(
    .W (W)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_grant),
    .i_dividend  (w_dividend),
    .i_divisor   (w_divisor),
    .i_step      (w_step),
    .i_zero_fin  (w_zero_fin),
    .o_last      (w_last),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_err       (err)
  );

endmodule

// File: tb/tb_div_arbiter_seq.sv
// Self-checking bench for div_arbiter_seq: cycle-level reference model plus
// directed scenarios with hand-computed results.
module tb_div_arbiter_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
  logic [1:0]   gnt, done;
  logic         busy, err;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  div_arbiter_seq #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in the current job (0 = idle), owner,
  // favoured requester, visible results and the results of the job in flight.
  int           m_left = 0;
  int           m_owner = 0;
  int           m_prio = 0;
  int           m_win;
  logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r, m_a, m_b;
  logic         m_e = 1'b0, p_e;
  logic [1:0]   m_eg, m_ed;
  int           cyc = 0;
  int           n_done = 0;
  int           last_gnt_cyc = 0;
  int           last_done_cyc = 0;
  int           gnt_log[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_left = 0;
      m_prio = 0;
      m_q    = '0;
      m_r    = '0;
      m_e    = 1'b0;
    end else begin
      m_eg  = 2'b00;
      m_win = 0;
      if (m_left == 0 && req != 2'b00) begin
        m_win = (req == 2'b11) ? m_prio : (req[1] ? 1 : 0);
        m_eg  = 2'(1 << m_win);
      end
      m_ed = (m_left == 1) ? 2'(1 << m_owner) : 2'b00;
      chk("gnt", gnt, m_eg);
      chk("busy", busy, m_left > 0);
      chk("done", done, m_ed);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("err", err, m_e);
      if (gnt != 2'b00) begin
        gnt_log.push_back(int'(gnt));
        last_gnt_cyc = cyc;
      end
      if (done != 2'b00) begin
        n_done++;
        last_done_cyc = cyc;
      end
      // advance to the next cycle
      if (m_left > 0) begin
        m_left--;
        if (m_left == 1) begin
          m_q = p_q; m_r = p_r; m_e = p_e;
        end
      end else if (m_eg != 2'b00) begin
        m_owner = m_win;
        m_prio  = 1 - m_win;
        m_a = m_win ? dividend1 : dividend0;
        m_b = m_win ? divisor1 : divisor0;
        m_left = W + 1;
        if (m_b != 0) begin
          p_q = m_a / m_b; p_r = m_a % m_b; p_e = 1'b0;
        end else begin
`ifdef DIV_ZERO_FLAG_EN
          p_q = '1; p_r = '1; p_e = 1'b1;
          m_left = 1;
          m_q = p_q; m_r = p_r; m_e = p_e;
`else
          p_q = '1; p_r = m_a; p_e = 1'b0;
`endif
        end
      end
    end
  end

  // One clock; drops any request that was granted at this edge.
  task automatic tick();
    logic [1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    req = req & ~g;
  endtask

  task automatic wait_done(input string name);
    int  start;
    bit  ok;
    start = n_done;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (n_done > start) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_completes"}, ok, 1);
  endtask

  task automatic do_reset();
    req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    if (id == 0) begin dividend0 = a; divisor0 = b; end
    else         begin dividend1 = a; divisor1 = b; end
    req[id] = 1'b1;
    wait_done(name);
  endtask

  int  start_done;
  bit  rereq;

  initial begin
    rst = 1'b1;
    req = 2'b00;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 7 / 2
    gnt_log.delete();
    run_op(0, 8'd7, 8'd2, "div7_2");
    chk("div7_2_q", quotient, 3);
    chk("div7_2_r", remainder, 1);
    chk("div7_2_err", err, 0);
    chk("div7_2_gnt", gnt_log.size() > 0 ? gnt_log[0] : 0, 1);
    chk("div7_2_latency", last_done_cyc - last_gnt_cyc, 9);

    // contention right after reset: requester 0 first
    do_reset();
    gnt_log.delete();
    dividend0 = 8'd100; divisor0 = 8'd7;
    dividend1 = 8'd255; divisor1 = 8'd16;
    req = 2'b11;
    wait_done("rr_first");
    chk("rr_first_q", quotient, 14);
    chk("rr_first_r", remainder, 2);
    wait_done("rr_second");
    chk("rr_second_q", quotient, 15);
    chk("rr_second_r", remainder, 15);
    chk("rr_order_n", gnt_log.size(), 2);
    chk("rr_order0", gnt_log.size() > 0 ? gnt_log[0] : 0, 1);
    chk("rr_order1", gnt_log.size() > 1 ? gnt_log[1] : 0, 2);

    // requester 0 re-requests at once while 1 is pending
    gnt_log.delete();
    start_done = n_done;
    rereq = 1'b0;
    dividend0 = 8'd20; divisor0 = 8'd6;
    dividend1 = 8'd30; divisor1 = 8'd4;
    req = 2'b11;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!rereq && !req[0]) begin
        dividend0 = 8'd50; divisor0 = 8'd5;
        req[0] = 1'b1;
        rereq = 1'b1;
      end
      if (n_done >= start_done + 3) break;
    end
    chk("alt_done_n", n_done - start_done, 3);
    chk("alt_order0", gnt_log.size() > 0 ? gnt_log[0] : 0, 1);
    chk("alt_order1", gnt_log.size() > 1 ? gnt_log[1] : 0, 2);
    chk("alt_order2", gnt_log.size() > 2 ? gnt_log[2] : 0, 1);
    chk("alt_last_q", quotient, 10);
    chk("alt_last_r", remainder, 0);

    // divide by zero
    run_op(0, 8'd9, 8'd0, "divzero");
`ifdef DIV_ZERO_FLAG_EN
    chk("divzero_latency", last_done_cyc - last_gnt_cyc, 1);
    chk("divzero_q", quotient, 8'hFF);
    chk("divzero_r", remainder, 8'hFF);
    chk("divzero_err", err, 1);
`else
    chk("divzero_latency", last_done_cyc - last_gnt_cyc, 9);
    chk("divzero_q", quotient, 8'hFF);
    chk("divzero_r", remainder, 9);
    chk("divzero_err", err, 0);
`endif

    // reset on the 4th iteration cycle aborts the job
    dividend0 = 8'd100; divisor0 = 8'd7;
    req[0] = 1'b1;
    tick();
    repeat (3) tick();
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_err", err, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    start_done = n_done;
    repeat (20) tick();
    chk("abort_no_done", n_done - start_done, 0);
    run_op(0, 8'd200, 8'd3, "div200_3");
    chk("div200_3_q", quotient, 66);
    chk("div200_3_r", remainder, 2);

    // extremes and result hold
    run_op(1, 8'd255, 8'd1, "div255_1");
    chk("div255_1_q", quotient, 255);
    chk("div255_1_r", remainder, 0);
    run_op(0, 8'd0, 8'd255, "div0_255");
    chk("div0_255_q", quotient, 0);
    chk("div0_255_r", remainder, 0);
    run_op(1, 8'd123, 8'd10, "div123_10");
    repeat (20) tick();
    chk("hold_q", quotient, 12);
    chk("hold_r", remainder, 3);
    chk("hold_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
